bist_fail_logger: RTL and testbench
===================================

Name: bist_fail_logger

Overview:
Result-side companion to the SRAM MBIST engine. It consumes the engine's per-read compare stream (address, expected pattern, RAM readback) and keeps a sticky pass/fail status and a saturating failure count. The first DEPTH failing reads are logged in a small FIFO as address plus XOR syndrome. A host or scan controller drains the FIFO through a valid/ready port for fault diagnosis and repair mapping.

Parameters:
ADDR_W, 6, RAM address width (64-word array)
DATA_W, 8, RAM word width
DEPTH, 4, fail-log FIFO entries (power of 2, >=2)
CNT_W, 10, failure counter width (saturating)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
test_start  input  1  pulse: clear log/status, begin capture
test_done  input  1  pulse: engine finished sequence (counter carry-out)
cmp_valid  input  1  a readback compare is presented this cycle
cmp_addr  input  ADDR_W  address of the compared word
cmp_expected  input  DATA_W  background pattern written
cmp_actual  input  DATA_W  RAM readback
log_valid  output  1  FIFO non-empty, head entry presented
log_ready  input  1  host accepts head entry
log_addr  output  ADDR_W  head entry failing address
log_syndrome  output  DATA_W  head entry expected XOR actual
log_bit  output  $clog2(DATA_W)  lowest set bit index of log_syndrome
fail  output  1  sticky: at least one mismatch since test_start
overflow  output  1  sticky: a mismatch was dropped because the FIFO was full
fail_count  output  CNT_W  mismatches since test_start, saturating at all-ones
busy  output  1  state == CAPTURE
done  output  1  state == REPORT

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; FIFO empty (wr/rd pointers 0, count 0); fail=0, overflow=0, fail_count=0, log_valid=0, busy=0, done=0. log_addr/log_syndrome/log_bit are 0 while the FIFO is empty.
- rst has priority over every other input.
- States:
  - IDLE -> CAPTURE on test_start.
  - CAPTURE -> REPORT on test_done.
  - CAPTURE -> CAPTURE on test_start (restart).
  - REPORT -> CAPTURE on test_start.
  - No other transitions.
- Entering CAPTURE: same edge clears FIFO, fail, overflow and fail_count. A cmp_valid in the test_start cycle is ignored.
- Mismatch: cmp_valid=1 && (cmp_expected ^ cmp_actual) != 0, while in CAPTURE. cmp_valid in IDLE or REPORT is ignored.
- On a mismatch:
  - fail<=1.
  - fail_count<=fail_count+1, unless it is already all-ones (hold).
  - Push {cmp_addr, syndrome} if the FIFO is not full, or if it is full and a pop occurs the same cycle. Otherwise drop the entry and set overflow<=1.
- test_done and a mismatch in the same cycle: the mismatch is recorded, then state moves to REPORT.
- Pop: log_valid && log_ready, allowed in any state. log_ready with an empty FIFO has no effect.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Full when count==DEPTH.
- Read port: log_addr, log_syndrome and log_bit are combinational from the head entry.
  - log_bit is the priority-encoded lowest set bit of log_syndrome.
  - Syndrome 0 never enters the FIFO.
- Latency: a mismatch sampled at edge N into an empty FIFO gives log_valid=1 after edge N. fail and fail_count update at the same edge.
- Status persistence: the FIFO, fail, overflow and fail_count hold through REPORT and IDLE until the next test_start or rst.
- rst mid-capture discards everything; the block does not resume.

Test Plan:
- Clean run: rst, test_start, 64 compares with expected==actual, test_done -> done=1, fail=0, fail_count=0, log_valid=0.
- Single fault: mismatch at addr 0x2A, expected 0x55, actual 0x51 -> next cycle log_valid=1, log_addr=0x2A, log_syndrome=0x04, log_bit=2, fail=1, fail_count=1. Pulse log_ready -> log_valid=0.
- Overflow: 6 mismatches at addrs 1..6, log_ready=0, DEPTH=4 -> fail_count=6, overflow=1. Drain yields addrs 1,2,3,4 in order, then log_valid=0.
- Full plus simultaneous pop: FIFO full and log_ready=1 while a mismatch at addr 0x3F arrives -> overflow stays 0, count stays 4, 0x3F is the last entry drained.
- Saturation (CNT_W=3 build): 10 mismatches -> fail_count=7 and holds.
- Restart and reset: test_start in REPORT with 2 entries logged -> FIFO empty, fail=0, busy=1. Then rst mid-capture after 1 mismatch -> all outputs 0, IDLE; cmp_valid in IDLE is ignored.

Source files
------------

// File: rtl/bist_fail_logger.sv
// bist_fail_logger
//   Result-side companion to the SRAM MBIST engine. Watches the per-read
//   compare stream, keeps sticky pass/fail and overflow flags plus a
//   saturating failure count, and logs the first DEPTH failing reads
//   (address + XOR syndrome) in a small FIFO that a host drains through a
//   valid/ready port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   test_start          pulse: clear log/status and begin capture
//   test_done           pulse: engine finished its sequence
//   cmp_valid/addr/expected/actual
//                       one readback compare per cycle
//   log_valid/ready     FIFO head handshake (pop = valid && ready)
//   log_addr/syndrome   head entry, zero while the FIFO is empty
//   log_bit             lowest set bit index of log_syndrome
//   fail, overflow      sticky status since test_start
//   fail_count          saturating mismatch count since test_start
//   busy, done          state == CAPTURE / state == REPORT
module bist_fail_logger #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      test_start,
    input  logic                      test_done,
    input  logic                      cmp_valid,
    input  logic [ADDR_W-1:0]         cmp_addr,
    input  logic [DATA_W-1:0]         cmp_expected,
    input  logic [DATA_W-1:0]         cmp_actual,
    output logic                      log_valid,
    input  logic                      log_ready,
    output logic [ADDR_W-1:0]         log_addr,
    output logic [DATA_W-1:0]         log_syndrome,
    output logic [$clog2(DATA_W)-1:0] log_bit,
    output logic                      fail,
    output logic                      overflow,
    output logic [CNT_W-1:0]          fail_count,
    output logic                      busy,
    output logic                      done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_syn  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic [DATA_W-1:0] syndrome;
    logic              mismatch;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] head_syn;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (test_start) state_next = CAPTURE;
            CAPTURE: begin
                if (test_start)     state_next = CAPTURE;
                else if (test_done) state_next = REPORT;
            end
            REPORT:  if (test_start) state_next = CAPTURE;
            default: state_next = IDLE;
        endcase
    end

    // A compare arriving with test_start is discarded, since that edge clears
    // the log; so mismatch excludes it.
    always_comb begin
        syndrome  = cmp_expected ^ cmp_actual;
        mismatch  = (state == CAPTURE) && !test_start && cmp_valid && (syndrome != '0);
        full      = (count == FULL_COUNT);
        log_valid = (count != '0);
        pop       = log_valid && log_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push      = mismatch && (!full || pop);
        drop      = mismatch && full && !pop;
        busy      = (state == CAPTURE);
        done      = (state == REPORT);
    end

    always_comb begin
        head_syn     = log_valid ? mem_syn[rd_ptr] : '0;
        log_syndrome = head_syn;
        log_addr     = log_valid ? mem_addr[rd_ptr] : '0;
        // Scan downwards so the last hit is the lowest set bit.
        log_bit      = '0;
        for (int unsigned i = DATA_W; i > 0; i--) begin
            if (head_syn[i-1]) log_bit = BIT_W'(i - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_addr[wr_ptr] <= cmp_addr;
            mem_syn[wr_ptr]  <= syndrome;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || test_start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fail       <= 1'b0;
            overflow   <= 1'b0;
            fail_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W + 1)'(1);
            else if (pop && !push) count <= count - (PTR_W + 1)'(1);
            if (mismatch) begin
                fail <= 1'b1;
                if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
            end
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bist_fail_logger.sv
// tb_bist_fail_logger
//   Directed bench for bist_fail_logger. A default build and a CNT_W=3 build
//   share one stimulus stream; expected values are hand-computed constants.
module tb_bist_fail_logger;

    logic       clk;
    logic       rst;
    logic       test_start;
    logic       test_done;
    logic       cmp_valid;
    logic [5:0] cmp_addr;
    logic [7:0] cmp_expected;
    logic [7:0] cmp_actual;
    logic       log_ready;

    logic       log_valid;
    logic [5:0] log_addr;
    logic [7:0] log_syndrome;
    logic [2:0] log_bit;
    logic       fail;
    logic       overflow;
    logic [9:0] fail_count;
    logic       busy;
    logic       done;

    logic       sat_log_valid;
    logic [5:0] sat_log_addr;
    logic [7:0] sat_log_syndrome;
    logic [2:0] sat_log_bit;
    logic       sat_fail;
    logic       sat_overflow;
    logic [2:0] sat_fail_count;
    logic       sat_busy;
    logic       sat_done;

    int n_vec;
    int n_miss;

    bist_fail_logger #(.ADDR_W(6), .DATA_W(8), .DEPTH(4), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .test_start(test_start), .test_done(test_done),
        .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_expected(cmp_expected),
        .cmp_actual(cmp_actual), .log_valid(log_valid), .log_ready(log_ready),
        .log_addr(log_addr), .log_syndrome(log_syndrome), .log_bit(log_bit),
        .fail(fail), .overflow(overflow), .fail_count(fail_count),
        .busy(busy), .done(done)
    );

    bist_fail_logger #(.ADDR_W(6), .DATA_W(8), .DEPTH(4), .CNT_W(3)) sat (
        .clk(clk), .rst(rst), .test_start(test_start), .test_done(test_done),
        .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_expected(cmp_expected),
        .cmp_actual(cmp_actual), .log_valid(sat_log_valid), .log_ready(log_ready),
        .log_addr(sat_log_addr), .log_syndrome(sat_log_syndrome), .log_bit(sat_log_bit),
        .fail(sat_fail), .overflow(sat_overflow), .fail_count(sat_fail_count),
        .busy(sat_busy), .done(sat_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        test_start = 1'b1;
        tick();
        test_start = 1'b0;
    endtask

    task automatic compare(input logic [5:0] a, input logic [7:0] e, input logic [7:0] act);
        cmp_valid    = 1'b1;
        cmp_addr     = a;
        cmp_expected = e;
        cmp_actual   = act;
        tick();
        cmp_valid    = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [5:0] a,
                              input logic [7:0] s, input logic [2:0] b);
        check_val({tag, "_valid"}, 32'(log_valid), 1);
        check_val({tag, "_addr"},  32'(log_addr), 32'(a));
        check_val({tag, "_syn"},   32'(log_syndrome), 32'(s));
        check_val({tag, "_bit"},   32'(log_bit), 32'(b));
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_log_valid"}, 32'(log_valid), 0);
        check_val({tag, "_log_addr"},  32'(log_addr), 0);
        check_val({tag, "_log_syn"},   32'(log_syndrome), 0);
        check_val({tag, "_log_bit"},   32'(log_bit), 0);
        check_val({tag, "_fail"},      32'(fail), 0);
        check_val({tag, "_overflow"},  32'(overflow), 0);
        check_val({tag, "_count"},     32'(fail_count), 0);
        check_val({tag, "_busy"},      32'(busy), 0);
        check_val({tag, "_done"},      32'(done), 0);
    endtask

    initial begin
        logic [7:0] act;
        n_vec        = 0;
        n_miss       = 0;
        rst          = 1'b1;
        test_start   = 1'b0;
        test_done    = 1'b0;
        cmp_valid    = 1'b0;
        cmp_addr     = '0;
        cmp_expected = '0;
        cmp_actual   = '0;
        log_ready    = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check_idle_zero("reset");

        // Mismatch while IDLE is ignored
        compare(6'h05, 8'hFF, 8'h00);
        check_val("idle_cmp_fail", 32'(fail), 0);
        check_val("idle_cmp_valid", 32'(log_valid), 0);

        // Clean run: 64 matching compares
        pulse_start();
        check_val("clean_busy", 32'(busy), 1);
        for (int i = 0; i < 64; i++) begin
            act = 8'(i * 37 + 5);
            compare(6'(i), act, act);
        end
        test_done = 1'b1;
        tick();
        test_done = 1'b0;
        check_val("clean_done", 32'(done), 1);
        check_val("clean_busy0", 32'(busy), 0);
        check_val("clean_fail", 32'(fail), 0);
        check_val("clean_count", 32'(fail_count), 0);
        check_val("clean_valid", 32'(log_valid), 0);

        // Single fault: 0x55 vs 0x51 -> syndrome 0x04, bit 2
        pulse_start();
        compare(6'h2A, 8'h55, 8'h51);
        check_head("single", 6'h2A, 8'h04, 3'd2);
        check_val("single_fail", 32'(fail), 1);
        check_val("single_count", 32'(fail_count), 1);
        check_val("single_ovf", 32'(overflow), 0);
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        check_val("single_popped", 32'(log_valid), 0);
        check_val("single_fail_sticky", 32'(fail), 1);

        // Overflow: six faults at addrs 1..6, lowest set bit = 8-i
        pulse_start();
        check_val("ovf_cleared_fail", 32'(fail), 0);
        for (int i = 1; i <= 6; i++) begin
            act = (8'h80 >> (i - 1)) | 8'h80;
            compare(6'(i), 8'h00, act);
        end
        check_val("ovf_count", 32'(fail_count), 6);
        check_val("ovf_flag", 32'(overflow), 1);
        check_val("ovf_sat_count", 32'(sat_fail_count), 6);
        log_ready = 1'b1;
        check_head("ovf_e1", 6'd1, 8'h80, 3'd7);
        tick();
        check_head("ovf_e2", 6'd2, 8'hC0, 3'd6);
        tick();
        check_head("ovf_e3", 6'd3, 8'hA0, 3'd5);
        tick();
        check_head("ovf_e4", 6'd4, 8'h90, 3'd4);
        tick();
        log_ready = 1'b0;
        check_val("ovf_empty", 32'(log_valid), 0);
        check_val("ovf_empty_addr", 32'(log_addr), 0);
        test_done = 1'b1;
        tick();
        test_done = 1'b0;
        check_val("ovf_done", 32'(done), 1);
        check_val("ovf_flag_sticky", 32'(overflow), 1);

        // Full FIFO plus simultaneous pop accepts the new entry
        pulse_start();
        for (int i = 0; i < 4; i++) compare(6'(8'h10 + i), 8'h00, 8'h01);
        check_val("full_ovf0", 32'(overflow), 0);
        log_ready = 1'b1;
        compare(6'h3F, 8'hFF, 8'h0F);
        check_val("fullpop_ovf", 32'(overflow), 0);
        check_val("fullpop_count", 32'(fail_count), 5);
        check_head("fullpop_e1", 6'h11, 8'h01, 3'd0);
        tick();
        check_head("fullpop_e2", 6'h12, 8'h01, 3'd0);
        tick();
        check_head("fullpop_e3", 6'h13, 8'h01, 3'd0);
        tick();
        check_head("fullpop_e4", 6'h3F, 8'hF0, 3'd4);
        tick();
        log_ready = 1'b0;
        check_val("fullpop_empty", 32'(log_valid), 0);

        // Saturation: ten faults, last one alongside test_done
        pulse_start();
        for (int i = 0; i < 9; i++) compare(6'(8'h20 + i), 8'h00, 8'(i + 1));
        test_done = 1'b1;
        compare(6'h29, 8'h00, 8'h0A);
        test_done = 1'b0;
        check_val("sat_count", 32'(sat_fail_count), 7);
        check_val("sat_main_count", 32'(fail_count), 10);
        check_val("sat_done", 32'(done), 1);
        compare(6'h30, 8'h00, 8'hFF);
        check_val("report_cmp_ignored", 32'(fail_count), 10);
        check_val("sat_hold", 32'(sat_fail_count), 7);

        // Pop allowed in REPORT; leave two entries, then restart
        log_ready = 1'b1;
        tick();
        tick();
        log_ready = 1'b0;
        check_head("report_pop", 6'h22, 8'h03, 3'd0);
        check_val("report_done", 32'(done), 1);
        test_start   = 1'b1;
        cmp_valid    = 1'b1;
        cmp_addr     = 6'h01;
        cmp_expected = 8'h00;
        cmp_actual   = 8'h01;
        tick();
        test_start = 1'b0;
        cmp_valid  = 1'b0;
        check_val("restart_valid", 32'(log_valid), 0);
        check_val("restart_fail", 32'(fail), 0);
        check_val("restart_count", 32'(fail_count), 0);
        check_val("restart_ovf", 32'(overflow), 0);
        check_val("restart_busy", 32'(busy), 1);

        // Reset mid-capture discards everything
        compare(6'h07, 8'h0F, 8'h0E);
        check_val("mid_valid", 32'(log_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("midrst");
        compare(6'h08, 8'h00, 8'h10);
        test_done = 1'b1;
        tick();
        test_done = 1'b0;
        check_val("postrst_fail", 32'(fail), 0);
        check_val("postrst_valid", 32'(log_valid), 0);
        check_val("postrst_done", 32'(done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
